tt_um_ajah_stott_holmes_serial_adder: RTL and testbench

TT_UM_AJAH_STOTT_HOLMES_SERIAL_ADDER -- requirements
Module: tt_um_ajah_stott_holmes_serial_adder

---
 rtl/tt_um_ajah_stott_holmes_serial_adder.sv | 104 ++++++++++
 tb/tb_tt_um_ajah_stott_holmes_serial_adder.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/tt_um_ajah_stott_holmes_serial_adder.sv
// Bit-serial WIDTH-bit adder: loads two operands, adds them LSB first over WIDTH cycles.
// Optional macro SERIAL_ADDER_ACCUM_EN adds accumulate mode and a sticky overflow flag.
module tt_um_ajah_stott_holmes_serial_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_next, op_a;
  logic [WIDTH:0]   result, sum_cat;
  logic [2:0]       cnt;
  logic             carry, bit_sum, bit_carry, last, start, acc, ovf, busy, done;
  logic             unused;

  assign start = uio_in[0];
  assign acc   = uio_in[1];
  assign last  = (cnt == 3'(WIDTH - 1));

  assign unused = &{1'b0, ena, ui_in, uio_in, acc};

  assign bit_sum   = a_sh[0] ^ b_sh[0] ^ carry;
  assign bit_carry = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  // Concatenate then drop the LSB so WIDTH=1 needs no empty slice
  assign sum_cat   = {bit_sum, sum_sh};
  assign sum_next  = sum_cat[WIDTH:1];

`ifdef SERIAL_ADDER_ACCUM_EN
  assign op_a = acc ? result[WIDTH-1:0] : ui_in[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (state == IDLE && start && !acc) begin
      ovf <= 1'b0;
    end else if (state == RUN && last && bit_carry) begin
      ovf <= 1'b1;
    end
  end
`else
  assign op_a = ui_in[WIDTH-1:0];
  assign ovf  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh  <= op_a;
          b_sh  <= ui_in[WIDTH+3:4];
          cnt   <= '0;
          carry <= 1'b0;
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_next;
          carry  <= bit_carry;
          cnt    <= cnt + 3'd1;
          if (last) result <= {bit_carry, sum_next};
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign uo_out  = 8'(result);
  assign uio_out = {busy, done, ovf, 5'b0};
  assign uio_oe  = 8'hE0;

endmodule

// File: tb/tb_tt_um_ajah_stott_holmes_serial_adder.sv
// Randomized bench for the serial adder, checked against a plain-arithmetic model.
// Define SERIAL_ADDER_ACCUM_EN for both files to exercise accumulate mode.
module tb_tt_um_ajah_stott_holmes_serial_adder;

  localparam int unsigned W = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = '0;
  logic [7:0] uio_in = '0;
  logic [7:0] uo_out, uio_out, uio_oe;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [4:0]  model_res = '0;
  logic        model_ovf = 1'b0;

  tt_um_ajah_stott_holmes_serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
    .uio_in(uio_in), .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic acc,
                        input bit poke);
    logic [3:0] op_a;
    logic [4:0] exp_res;
    logic       ovf_run;
    op_a    = a;
    ovf_run = 1'b0;
`ifdef SERIAL_ADDER_ACCUM_EN
    if (acc) op_a = model_res[3:0];
    ovf_run = acc ? model_ovf : 1'b0;
`endif
    exp_res = {1'b0, op_a} + {1'b0, b};

    @(negedge clk);
    ui_in  = {b, a};
    uio_in = {6'($urandom), acc, 1'b1};
    ena    = 1'($urandom);
    @(posedge clk);
    #1 uio_in[0] = 1'b0;
    for (int k = 0; k < int'(W); k++) begin
      @(negedge clk);
      check("busy_run", 16'(uio_out[7]), 16'd1);
      check("done_run", 16'(uio_out[6]), 16'd0);
      check("hold_run", 16'(uo_out), 16'(model_res));
      check("ovf_run",  16'(uio_out[5]), 16'(ovf_run));
      if (poke && k == 1) begin
        uio_in[0] = 1'b1;
        ui_in     = 8'($urandom);
      end
      if (poke && k == 2) uio_in[0] = 1'b0;
    end
    @(negedge clk);
    check("done_pulse", 16'(uio_out[6]), 16'd1);
    check("busy_done",  16'(uio_out[7]), 16'd0);
    check("sum",        16'(uo_out), 16'(exp_res));
    model_res = exp_res;
`ifdef SERIAL_ADDER_ACCUM_EN
    model_ovf = ovf_run | exp_res[4];
`endif
    check("ovf_done", 16'(uio_out[5]), 16'(model_ovf));
    @(negedge clk);
    check("idle_flags", 16'(uio_out), {8'd0, 2'b00, model_ovf, 5'd0});
    check("idle_hold",  16'(uo_out), 16'(model_res));
  endtask

  initial begin
    int unsigned gap;
    bit          seen;

    #1 rst_n = 1'b0;
    #1;
    check("rst_uo",  16'(uo_out), 16'h00);
    check("rst_uio", 16'(uio_out), 16'h00);
    check("rst_oe",  16'(uio_oe), 16'hE0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(4'h5, 4'h3, 1'b0, 1'b0);   // 0x35 -> 0x08
    run_op(4'hF, 4'h1, 1'b0, 1'b1);   // 0x1F -> 0x10, start poked mid-run
`ifdef SERIAL_ADDER_ACCUM_EN
    run_op(4'h5, 4'h3, 1'b0, 1'b0);   // result 0x08
    run_op(4'h0, 4'h9, 1'b1, 1'b0);   // acc: 8+9 -> 0x11, ovf
    run_op(4'h1, 4'h2, 1'b0, 1'b0);   // acc=0 clears ovf
`endif

    for (int i = 0; i < 24; i++)
      run_op(4'($urandom), 4'($urandom), 1'($urandom), bit'($urandom));

    // Start held high: operations repeat every W+2 cycles
    @(negedge clk);
    ui_in  = 8'h35;
    uio_in = 8'h01;
    seen   = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      seen = uio_out[6];
    end
    check("b2b_first_done", 16'(seen), 16'd1);
    gap  = 0;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      gap++;
      seen = uio_out[6];
    end
    check("b2b_period", 16'(gap), 16'(W + 2));
    check("b2b_sum", 16'(uo_out), 16'h08);
    uio_in = 8'h00;
    model_res = 5'h08;
`ifdef SERIAL_ADDER_ACCUM_EN
    model_ovf = 1'b0;
`endif
    repeat (2) @(negedge clk);

    // Reset asserted during RUN cycle 2
    @(negedge clk);
    ui_in  = 8'h77;
    uio_in = 8'h01;
    @(posedge clk);
    #1 uio_in = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_uo",  16'(uo_out), 16'h00);
    check("midrst_uio", 16'(uio_out), 16'h00);
    check("midrst_oe",  16'(uio_oe), 16'hE0);
    model_res = '0;
    model_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4'h9, 4'h4, 1'b0, 1'b0);
    run_op(4'($urandom), 4'($urandom), 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
